// File: rtl/input_line_buffer_bank.sv
// Line-buffer bank: per-line column RAMs written by the buffer exchanger, read out as a
// 1- or 3-row vertical window through a 2-deep output FIFO with valid/ready handshake.

module input_line_buffer_line #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Non-blocking read and write on the same edge gives read-before-write.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

module input_line_buffer_bank #(
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int LINE_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LINES-1:0]   ex_we,
  input  logic [ADDR_W-1:0]      ex_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_start,
  input  logic [LINE_W-1:0]      rd_line,
  input  logic [ADDR_W-1:0]      rd_last,
  input  logic                   kernelsize_op,
  output logic [3*DATA_W-1:0]    win_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   busy,
  output logic                   rd_done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               col_q, col_d;
  logic [LINE_W-1:0]               line_q;
  logic [ADDR_W-1:0]               last_q;
  logic                            ks_q;
  logic                            infl_q;
  logic [1:0]                      cnt_q;
  logic                            wptr_q, rptr_q;
  logic [1:0][3*DATA_W-1:0]        fifo_q;
  logic                            rd_done_q, done_d;

  logic [NUM_LINES-1:0][DATA_W-1:0] line_rd;
  logic [2:0][DATA_W-1:0]          win_w;
  logic [LINE_W-1:0]               row1, row2;
  logic [2:0]                      occ_nxt;
  logic                            pop, issue, last_pop;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    input_line_buffer_line #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_line (
      .clk     (clk),
      .we_i    (ex_we[i]),
      .waddr_i (ex_addr),
      .wdata_i (wr_data),
      .re_i    (issue),
      .raddr_i (col_q),
      .rdata_o (line_rd[i])
    );
  end

  assign row1 = line_q + LINE_W'(1);
  assign row2 = line_q + LINE_W'(2);

  assign win_w[0] = line_rd[line_q];
  assign win_w[1] = ks_q ? line_rd[row1] : '0;
  assign win_w[2] = ks_q ? line_rd[row2] : '0;

  assign win_valid = (cnt_q != 2'd0);
  assign win_data  = fifo_q[rptr_q];
  assign busy      = (state_q != IDLE);
  assign rd_done   = rd_done_q;

  assign pop = win_valid && win_ready;
  // Occupancy after this edge must leave room for one more in-flight word.
  assign occ_nxt  = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
  assign issue    = (state_q == READ) && (occ_nxt < 3'd2);
  assign last_pop = pop && (cnt_q == 2'd1) && !infl_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (rd_start) begin
        state_d = READ;
        col_d   = '0;
      end
      READ: if (issue) begin
        col_d = col_q + ADDR_W'(1);
        if (col_q == last_q) state_d = DRAIN;
      end
      DRAIN: if (last_pop) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      line_q    <= '0;
      last_q    <= '0;
      ks_q      <= 1'b0;
      infl_q    <= 1'b0;
      cnt_q     <= 2'd0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      fifo_q    <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      rd_done_q <= done_d;
      infl_q    <= issue;
      if (state_q == IDLE && rd_start) begin
        line_q <= rd_line;
        last_q <= rd_last;
        ks_q   <= kernelsize_op;
      end
      if (infl_q) begin
        fifo_q[wptr_q] <= {win_w[2], win_w[1], win_w[0]};
        wptr_q         <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end
endmodule

// File: doc/input_line_buffer_bank.md
Name: input_line_buffer_bank

Overview:
Input feature-map line-buffer bank that sits directly downstream of the buffer exchanger. It stores each incoming column word into the line(s) selected by the exchanger's one-hot/two-hot write enables at the exchanger address. On request, it streams a vertical window of 1 or 3 consecutive lines, column by column, to the PE array through a valid/ready handshake. Line indices wrap modulo NUM_LINES, so the exchanger's rotating write pattern and the read window stay consistent.

Parameters:
NUM_LINES, 32, number of line buffers; must match exchanger write-enable width
ADDR_W, 8, column address width; each line is 2**ADDR_W words deep
DATA_W, 16, width of one column word
LINE_W, 5, line index width, log2(NUM_LINES)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
ex_we  input  NUM_LINES  per-line write enables from the exchanger; any number of bits may be set
ex_addr  input  ADDR_W  write column address from the exchanger
wr_data  input  DATA_W  write data, qualified by ex_we
rd_start  input  1  single-cycle pulse that starts a window read
rd_line  input  LINE_W  index of the top window row
rd_last  input  ADDR_W  last column address to read; the read covers columns 0..rd_last
kernelsize_op  input  1  1 = 3-row window; 0 = 1-row window
win_data  output  3*DATA_W  {row2,row1,row0}; row0 = line rd_line, in the LSBs
win_valid  output  1  win_data valid
win_ready  input  1  consumer accepts win_data
busy  output  1  high while a read is in progress (not IDLE)
rd_done  output  1  one-cycle pulse after the final column is accepted

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; column counter = 0; output FIFO emptied; in-flight read flag cleared; win_valid = 0, win_data = 0, busy = 0, rd_done = 0. Memory contents are not reset.
- Write: each cycle, for every i with ex_we[i] = 1, line[i][ex_addr] <= wr_data. Writes are accepted in every state, including during a read.
- Read memory: synchronous, 1-cycle latency.
- Read-during-write, same line and same address in the same cycle: the read returns the old data (read-before-write).
- FSM states: IDLE, READ, DRAIN.
- IDLE: on rd_start = 1, latch rd_line, rd_last and kernelsize_op; set column counter = 0; go to READ; busy = 1 from the next cycle.
- rd_start is ignored in READ and DRAIN. The latched parameters are not affected by later changes on rd_line, rd_last or kernelsize_op.
- READ: issue the read of column col on rows (L, L+1, L+2) mod NUM_LINES whenever occupancy + in-flight < 2. The output FIFO is 2 deep.
  - On issue: col increments.
  - Issuing col == rd_last moves the FSM to DRAIN.
- DRAIN: no more issues. Once the final column's win_valid & win_ready handshake completes, go to IDLE.
  - busy = 0 in the following cycle.
  - rd_done = 1 for exactly that one cycle.
- kernelsize_op = 0: row1 and row2 fields are driven to 0; only line L is read.
- Latency: rd_start sampled at edge T → first win_valid = 1 after edge T+2.
  - With win_ready held at 1: one column per cycle, no bubbles.
  - The last column appears after edge T+2+rd_last; rd_done is high after edge T+3+rd_last.
- Handshake: while win_valid = 1 and win_ready = 0, win_data and win_valid are held stable. Columns are delivered exactly once, in ascending order, with no loss and no duplication.
- win_valid never depends combinationally on win_ready.
- rd_last = 0: a single-column read; DRAIN is entered right after the first issue.
- Row wrap: the L+1 and L+2 computations are LINE_W-bit modular arithmetic (31+1 → 0).
- Asynchronous reset mid-read: everything returns to the reset values immediately; the read is abandoned and no rd_done is produced.

Test Plan:
1. Preload line n, column c with n*256+c for n = 0..2, c = 0..3. Then rd_start, rd_line = 0, rd_last = 3, kernelsize_op = 1, win_ready = 1 → win_valid high after edges T+2..T+5; first word {0x0200,0x0100,0x0000}, last word {0x0203,0x0103,0x0003}; rd_done pulses once after T+6; busy then falls.
2. Wrap: rd_line = 31, rd_last = 0 → single beat {line1[0], line0[0], line31[0]}; rd_done one cycle later.
3. Backpressure: as in 1, drop win_ready for 3 cycles while column 1 is presented → column 1 is held unchanged, then columns 1, 2, 3 are delivered in order with no duplicates; rd_done appears only after column 3 is accepted.
4. kernelsize_op = 0, rd_line = 5, rd_last = 1 → win_data[3*DATA_W-1:DATA_W] = 0; low field equals line5[0] then line5[1].
5. ex_we = 32'h3, ex_addr = 7, wr_data = 0xABCD writes lines 0 and 1 together. In the same cycle, a read of line 0, column 7 is issued → the read returns the prior contents; a later read returns 0xABCD on both rows.
6. rd_start pulsed in READ (rd_line = 9) is ignored; the original window completes. Then assert rst low mid-read → win_valid, busy and rd_done = 0 immediately, with no rd_done. Release rst and issue rd_start → the read runs normally with the test 1 timing.
